lmmi_cfg_sequencer: RTL and testbench

- Script-driven configuration master for an LMMI register port, e.g. the I2C_DPHY_x controller that programs the camera sensor, or a MIPI_DPHY_x LMMI port.
- Fetches 16-bit command words from an external synchronous script ROM and executes them in order: WRITE, POLL, WAIT, END.
- Handles LMMI request/ready and read-data handshakes, poll retries and timeouts, and reports done or error to the bring-up logic.

---
 rtl/lmmi_cfg_sequencer_pkg.sv | 34 +++
 rtl/lmmi_cfg_sequencer_if.sv | 27 ++
 rtl/lmmi_cfg_sequencer_timer.sv | 28 ++
 rtl/lmmi_cfg_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_lmmi_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lmmi_cfg_sequencer_pkg.sv
// Shared types and script-word layout for the LMMI configuration sequencer.
package lmmi_seq_pkg;

    localparam int SCRIPT_W = 16;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 14;
    localparam int OFF_MSB  = 13;
    localparam int OFF_LSB  = 10;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_POLL  = 2'b01,
        OP_WAIT  = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_DELAY  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lmmi_cfg_sequencer_if.sv
// Script ROM port plus LMMI register port, seen from the sequencer (master) side.
interface lmmi_cfg_sequencer_if #(
    parameter int ADDR_W = 8
);
    import lmmi_seq_pkg::*;

    logic [ADDR_W-1:0]   script_addr_o;
    logic [SCRIPT_W-1:0] script_data_i;
    logic                lmmi_request_o;
    logic                lmmi_wr_rdn_o;
    logic [3:0]          lmmi_offset_o;
    logic [7:0]          lmmi_wdata_o;
    logic [7:0]          lmmi_rdata_i;
    logic                lmmi_rdata_valid_i;
    logic                lmmi_ready_i;

    modport master (
        output script_addr_o, lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o,
        input  script_data_i, lmmi_rdata_i, lmmi_rdata_valid_i, lmmi_ready_i
    );

    modport slave (
        input  script_addr_o, lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o,
        output script_data_i, lmmi_rdata_i, lmmi_rdata_valid_i, lmmi_ready_i
    );

endinterface

// File: rtl/lmmi_cfg_sequencer_timer.sv
// Loadable down-counter with zero flag; shared by the handshake timeout and WAIT delay.
module lmmi_seq_timer #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         sync_rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] r_count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_count <= {W{1'b0}};
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != {W{1'b0}})) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero_o = (r_count == {W{1'b0}});

endmodule

// File: rtl/lmmi_cfg_sequencer.sv
// Script-driven LMMI configuration master: fetches 16-bit command words and
// executes WRITE / POLL / WAIT / END, reporting done or error with the failing address.
module lmmi_cfg_sequencer
    import lmmi_seq_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 1024,
    parameter int POLL_MAX   = 255,
    parameter int WAIT_SCALE = 256
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    lmmi_cfg_sequencer_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int DLY_W = 8 + $clog2(WAIT_SCALE);
    localparam int TMR_W = max_int(TMO_W, DLY_W);
    localparam int ATT_W = $clog2(POLL_MAX + 1);

    state_e            r_state, w_state_nxt;
    op_e               r_op, w_op;
    logic [7:0]        w_data, r_mask, r_wdata, r_rd_data, w_rd_data;
    logic [3:0]        r_offset;
    logic              r_wr_rdn, r_req, r_busy, r_done, r_error, r_have_rd;
    logic [ADDR_W-1:0] r_addr, r_err_addr;
    logic [ATT_W-1:0]  r_attempts;
    logic              w_rd_valid, w_rd_hit;
    logic              w_start, w_latch, w_addr_inc, w_attempt_inc, w_capture, w_fail, w_next_entry;
    logic              w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_unused_bits;

    assign w_op          = op_e'(bus.script_data_i[OP_MSB:OP_LSB]);
    assign w_data        = bus.script_data_i[DATA_MSB:DATA_LSB];
    assign w_unused_bits = ^bus.script_data_i[9:8];

    // Read data may have arrived together with ready while still in ISSUE.
    assign w_rd_valid = r_have_rd | bus.lmmi_rdata_valid_i;
    assign w_rd_data  = r_have_rd ? r_rd_data : bus.lmmi_rdata_i;
    assign w_rd_hit   = ((w_rd_data & r_mask) != 8'h00);

    lmmi_seq_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .dec_i      (w_tmr_dec),
        .zero_o     (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_latch       = 1'b0;
        w_addr_inc    = 1'b0;
        w_attempt_inc = 1'b0;
        w_capture     = 1'b0;
        w_fail        = 1'b0;
        w_next_entry  = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;
        w_tmr_val     = TMR_W'(TIMEOUT - 1);
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FETCH: w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                w_latch = 1'b1;
                case (w_op)
                    OP_WRITE, OP_POLL: begin
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                    OP_WAIT: begin
                        if (w_data != 8'h00) begin
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = TMR_W'(w_data) * TMR_W'(WAIT_SCALE) - TMR_W'(1);
                            w_state_nxt = ST_DELAY;
                        end else begin
                            w_next_entry = 1'b1;
                        end
                    end
                    OP_END:  w_state_nxt = ST_DONE;
                    default: w_fail = 1'b1;
                endcase
            end
            ST_ISSUE: begin
                if (bus.lmmi_ready_i) begin
                    if (r_op == OP_POLL) begin
                        w_capture   = bus.lmmi_rdata_valid_i;
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_RDWAIT;
                    end else begin
                        w_next_entry = 1'b1;
                    end
                end else if (w_tmr_zero) begin
                    w_fail = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (w_rd_valid) begin
                    if (w_rd_hit) begin
                        w_next_entry = 1'b1;
                    end else if (r_attempts < ATT_W'(POLL_MAX)) begin
                        w_attempt_inc = 1'b1;
                        w_tmr_load    = 1'b1;
                        w_state_nxt   = ST_ISSUE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_tmr_zero) begin
                    w_fail = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DELAY: begin
                if (w_tmr_zero) begin
                    w_next_entry = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_fail = 1'b1;
        endcase

        // Advancing past the last ROM word without END is an overrun, never a wrap.
        if (w_next_entry) begin
            if (r_addr == {ADDR_W{1'b1}}) begin
                w_fail = 1'b1;
            end else begin
                w_addr_inc  = 1'b1;
                w_state_nxt = ST_FETCH;
            end
        end else begin
            w_addr_inc = 1'b0;
        end

        if (w_fail) begin
            w_state_nxt = ST_ERROR;
        end else begin
            w_start = w_start;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_err_addr <= {ADDR_W{1'b0}};
            r_op       <= OP_WRITE;
            r_mask     <= 8'h00;
            r_offset   <= 4'h0;
            r_wr_rdn   <= 1'b0;
            r_wdata    <= 8'h00;
            r_attempts <= {ATT_W{1'b0}};
            r_have_rd  <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE) && (w_state_nxt != ST_ERROR);
            r_done  <= (w_state_nxt == ST_DONE);
            r_error <= (w_state_nxt == ST_ERROR);
            r_req   <= (w_state_nxt == ST_ISSUE);
            if (w_start) begin
                r_addr     <= {ADDR_W{1'b0}};
                r_err_addr <= {ADDR_W{1'b0}};
            end else if (w_fail) begin
                r_err_addr <= r_addr;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_latch) begin
                r_op       <= w_op;
                r_mask     <= w_data;
                r_offset   <= bus.script_data_i[OFF_MSB:OFF_LSB];
                r_wr_rdn   <= (w_op == OP_WRITE);
                r_wdata    <= (w_op == OP_WRITE) ? w_data : 8'h00;
                r_attempts <= {ATT_W{1'b0}};
            end else if (w_attempt_inc) begin
                r_attempts <= r_attempts + ATT_W'(1);
            end
            if (w_capture) begin
                r_have_rd <= 1'b1;
                r_rd_data <= bus.lmmi_rdata_i;
            end else if (r_state == ST_RDWAIT) begin
                r_have_rd <= 1'b0;
            end
        end
    end

    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign error_o            = r_error;
    assign err_addr_o         = r_err_addr;
    assign bus.script_addr_o  = r_addr;
    assign bus.lmmi_request_o = r_req;
    assign bus.lmmi_wr_rdn_o  = r_wr_rdn;
    assign bus.lmmi_offset_o  = r_offset;
    assign bus.lmmi_wdata_o   = r_wdata;

endmodule

// File: tb/tb_lmmi_cfg_sequencer.sv
// Scoreboard bench: a script-level reference model predicts LMMI transfers and the
// final status; a negedge monitor pops and compares as the DUT produces them.
module tb_lmmi_cfg_sequencer;
    import lmmi_seq_pkg::*;

    localparam int ADDR_W     = 3;
    localparam int TIMEOUT    = 16;
    localparam int POLL_MAX   = 3;
    localparam int WAIT_SCALE = 4;
    localparam int ROM_N      = 8;

    typedef struct packed { logic wr; logic [3:0] off; logic [7:0] wd; } xact_t;
    typedef struct packed { logic d; logic e; logic [ADDR_W-1:0] addr; } st_t;

    logic clk = 1'b0;
    logic sync_rst, start, busy, done, error;
    logic [ADDR_W-1:0] err_addr;

    lmmi_cfg_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    lmmi_cfg_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .POLL_MAX(POLL_MAX),
                         .WAIT_SCALE(WAIT_SCALE)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst), .start_i(start), .busy_o(busy),
        .done_o(done), .error_o(error), .err_addr_o(err_addr), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, st_cyc = 0, fin_cyc = 0, comp_cnt = 0, req_hi_cnt = 0;
    logic fin_busy = 1'b0;
    logic [15:0] rom [ROM_N];
    int rd_list [64];
    int vdel [64];
    int rd_idx = 0;
    bit ready_never = 1'b0, rdy_zero = 1'b0;
    xact_t exp_q [$];
    st_t   st_q [$];
    int    acc_t [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] w(input int op, input int off, input int d);
        return 16'(((op & 3) << 14) | ((off & 15) << 10) | (d & 255));
    endfunction

    // Reference model: walk the script as the rules describe, using the responder's read list.
    task automatic build_expect();
        int a, k, op, off, d;
        bit fin, hit;
        xact_t x;
        st_t s;
        a = 0; k = 0; fin = 1'b0;
        exp_q.delete(); st_q.delete();
        while (!fin) begin
            op = (rom[a] >> 14) & 3; off = (rom[a] >> 10) & 15; d = rom[a] & 255;
            if (op == 3) begin
                s.d = 1'b1; s.e = 1'b0; s.addr = '0; st_q.push_back(s); fin = 1'b1;
            end else begin
                if (op == 0) begin
                    x.wr = 1'b1; x.off = 4'(off); x.wd = 8'(d); exp_q.push_back(x);
                end else if (op == 1) begin
                    hit = 1'b0;
                    for (int att = 0; att <= POLL_MAX; att++) begin
                        x.wr = 1'b0; x.off = 4'(off); x.wd = 8'h00; exp_q.push_back(x);
                        hit = ((rd_list[k] & d) != 0);
                        k++;
                        if (hit) break;
                    end
                    if (!hit) begin
                        s.d = 1'b0; s.e = 1'b1; s.addr = ADDR_W'(a); st_q.push_back(s); fin = 1'b1;
                    end
                end
                if (!fin) begin
                    if (a == ROM_N - 1) begin
                        s.d = 1'b0; s.e = 1'b1; s.addr = ADDR_W'(a); st_q.push_back(s); fin = 1'b1;
                    end else begin
                        a++;
                    end
                end
            end
        end
    endtask

    // Synchronous script ROM (one cycle latency) and cycle counter.
    initial begin
        bus.script_data_i = 16'h0000;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            bus.script_data_i <= rom[bus.script_addr_o];
        end
    end

    // LMMI responder: random ready delay, read data from rd_list with vdel-cycle valid lag.
    initial begin
        int rcnt, vcnt, vd, cur_rd;
        rcnt = -1; vcnt = 0; cur_rd = 0;
        bus.lmmi_ready_i = 1'b0; bus.lmmi_rdata_valid_i = 1'b0; bus.lmmi_rdata_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.lmmi_ready_i = 1'b0;
            bus.lmmi_rdata_valid_i = 1'b0;
            bus.lmmi_rdata_i = 8'($urandom);
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) begin
                    bus.lmmi_rdata_valid_i = 1'b1; bus.lmmi_rdata_i = 8'(cur_rd);
                end
            end else if (bus.lmmi_request_o && !ready_never) begin
                if (rcnt < 0) rcnt = rdy_zero ? 0 : int'($urandom_range(0, 3));
                if (rcnt == 0) begin
                    bus.lmmi_ready_i = 1'b1;
                    rcnt = -1;
                    if (!bus.lmmi_wr_rdn_o) begin
                        cur_rd = rd_list[rd_idx % 64]; vd = vdel[rd_idx % 64]; rd_idx++;
                        if (vd == 0) begin
                            bus.lmmi_rdata_valid_i = 1'b1; bus.lmmi_rdata_i = 8'(cur_rd);
                        end else begin
                            vcnt = vd;
                        end
                    end
                end else begin
                    rcnt--;
                end
            end
        end
    end

    // Monitor: compare accepted transfers and completion status against the queues.
    initial begin : monitor
        xact_t x;
        st_t s;
        logic fin, prev_fin;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.lmmi_request_o) req_hi_cnt++;
            if (bus.lmmi_request_o && bus.lmmi_ready_i) begin
                acc_t.push_back(cyc);
                chk("xact_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    chk("xact_wr_rdn", bus.lmmi_wr_rdn_o, x.wr);
                    chk("xact_offset", bus.lmmi_offset_o, x.off);
                    if (x.wr) chk("xact_wdata", bus.lmmi_wdata_o, x.wd);
                end
            end
            fin = done | error;
            if (fin && !prev_fin) begin
                fin_cyc = cyc; fin_busy = busy; comp_cnt++;
                chk("status_expected", int'(st_q.size() > 0), 1);
                if (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    chk("done_o", done, s.d);
                    chk("error_o", error, s.e);
                    if (s.e) chk("err_addr_o", err_addr, s.addr);
                end
            end
            prev_fin = fin;
        end
    end

    task automatic run_script(input bit use_model);
        int c0;
        if (use_model) build_expect();
        acc_t.delete(); req_hi_cnt = 0; rd_idx = 0;
        @(posedge clk); #1;
        c0 = comp_cnt; start = 1'b1; st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (comp_cnt != c0) break;
            @(posedge clk);
        end
        chk("finish_seen", comp_cnt - c0, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("pending_xacts", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_addr"}, err_addr, 0);
        chk({tag, "_request"}, bus.lmmi_request_o, 0);
        chk({tag, "_wr_rdn"}, bus.lmmi_wr_rdn_o, 0);
        chk({tag, "_offset"}, bus.lmmi_offset_o, 0);
        chk({tag, "_wdata"}, bus.lmmi_wdata_o, 0);
        chk({tag, "_script_addr"}, bus.script_addr_o, 0);
    endtask

    initial begin
        st_t s;
        int n, kind;
        sync_rst = 1'b1; start = 1'b0;
        for (int i = 0; i < ROM_N; i++) rom[i] = w(3, 0, 0);
        for (int i = 0; i < 64; i++) begin rd_list[i] = 0; vdel[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        sync_rst = 1'b0;

        // WRITE then END with zero-latency ready: done in cycle 6, busy falls together.
        rdy_zero = 1'b1;
        rom[0] = w(0, 3, 8'h5A); rom[1] = w(3, 0, 0);
        run_script(1'b1);
        chk("done_latency", fin_cyc - st_cyc, 6);
        chk("busy_at_done", fin_busy, 0);

        // POLL: two misses then a hit with valid two cycles after ready.
        rdy_zero = 1'b0;
        rom[0] = w(1, 1, 8'h01); rom[1] = w(3, 0, 0);
        rd_list[0] = 8'h00; vdel[0] = 0; rd_list[1] = 8'h00; vdel[1] = 1;
        rd_list[2] = 8'h81; vdel[2] = 2;
        run_script(1'b1);
        chk("poll_reads", acc_t.size(), 3);

        // POLL exhaustion: 1 + POLL_MAX reads then error at the POLL entry.
        rom[0] = w(0, 7, 8'hC3); rom[1] = w(1, 2, 8'h10); rom[2] = w(3, 0, 0);
        for (int i = 0; i < 8; i++) begin rd_list[i] = 8'hEF; vdel[i] = i % 3; end
        run_script(1'b1);
        chk("exhaust_xacts", acc_t.size(), 1 + POLL_MAX + 1);

        // Ready never returns: request held exactly TIMEOUT cycles, then error at entry 0.
        ready_never = 1'b1;
        rom[0] = w(0, 5, 8'h33); rom[1] = w(3, 0, 0);
        exp_q.delete(); st_q.delete();
        s.d = 1'b0; s.e = 1'b1; s.addr = '0; st_q.push_back(s);
        run_script(1'b0);
        chk("timeout_req_cycles", req_hi_cnt, TIMEOUT);
        chk("timeout_req_low", bus.lmmi_request_o, 0);
        ready_never = 1'b0;

        // WAIT spacing between consecutive write acceptances.
        rdy_zero = 1'b1;
        for (int dw = 0; dw < 3; dw += 2) begin
            rom[0] = w(0, 1, 8'h11); rom[1] = w(2, 0, dw); rom[2] = w(0, 2, 8'h22); rom[3] = w(3, 0, 0);
            run_script(1'b1);
            chk("wait_gap_count", acc_t.size(), 2);
            if (acc_t.size() == 2) chk("wait_gap_cycles", acc_t[1] - acc_t[0], 5 + dw * WAIT_SCALE);
        end

        // start while busy is ignored: any restart would produce extra transfers.
        rom[0] = w(0, 2, 8'h44); rom[1] = w(2, 0, 3); rom[2] = w(0, 4, 8'h55); rom[3] = w(3, 0, 0);
        fork
            run_script(1'b1);
            begin
                repeat (9) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join

        // Overrun: eight WRITEs and no END.
        for (int i = 0; i < ROM_N; i++) rom[i] = w(0, i, 8'(i * 17 + 1));
        run_script(1'b1);

        // Reset while request is high: everything back to zero on the next edge.
        ready_never = 1'b1;
        rom[0] = w(0, 9, 8'h77); rom[1] = w(3, 0, 0);
        exp_q.delete(); st_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.lmmi_request_o) break;
            @(posedge clk); #1;
        end
        chk("req_before_reset", bus.lmmi_request_o, 1);
        sync_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        sync_rst = 1'b0; ready_never = 1'b0;

        // Randomized scripts against the reference model.
        rdy_zero = 1'b0;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, ROM_N);
            for (int a = 0; a < ROM_N; a++) begin
                kind = $urandom_range(0, 2);
                if (kind == 0) rom[a] = w(0, $urandom, $urandom);
                else if (kind == 1) rom[a] = w(1, $urandom, $urandom);
                else rom[a] = w(2, $urandom, $urandom_range(0, 2));
                rom[a] = rom[a] | 16'(($urandom & 3) << 8);
            end
            if (n < ROM_N) rom[n] = w(3, $urandom, $urandom);
            for (int i = 0; i < 64; i++) begin
                rd_list[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
                vdel[i] = $urandom_range(0, 3);
            end
            run_script(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
